// File: rtl/strip_alloc_engine.sv
// strip_alloc_engine: best-fit strip-packing allocator for the program-placement array.
// Scans STRIPS_PER_CYCLE strips per clock, then places the program or strikes it.
module strip_alloc_engine #(
   parameter int                      ARRAY_W          = 128,
   parameter int                      ARRAY_H          = 128,
   parameter int                      NUM_STRIPS       = 13,
   parameter logic [NUM_STRIPS*5-1:0] STRIP_HEIGHTS    = {5'd12, 5'd4, 5'd11, 5'd5, 5'd10, 5'd6, 5'd9,
                                                          5'd7, 5'd8, 5'd8, 5'd16, 5'd16, 5'd16},
   parameter int                      STRIPS_PER_CYCLE = 4,
   parameter int                      SLACK            = 1,
   parameter int                      TALL_MIN         = 13
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       req_valid_i,
   output logic       req_ready_o,
   input  logic [4:0] height_i,
   input  logic [7:0] width_i,
   input  logic       clear_i,
   output logic       resp_valid_o,
   input  logic       resp_ready_i,
   output logic [1:0] strike_o,
   output logic [7:0] index_x_o,
   output logic [7:0] index_y_o,
   output logic [3:0] strike_cnt_o
);
   localparam int NSCAN = (NUM_STRIPS + STRIPS_PER_CYCLE - 1) / STRIPS_PER_CYCLE;

   // strip 0 sits in the most significant field of STRIP_HEIGHTS
   function automatic logic [4:0] hgt(input int s);
      return STRIP_HEIGHTS[(NUM_STRIPS-1-s)*5 +: 5];
   endfunction

   function automatic logic [4:0] hmax();
      logic [4:0] m = '0;
      for (int i = 0; i < NUM_STRIPS; i++) m = hgt(i) > m ? hgt(i) : m;
      return m;
   endfunction

   function automatic int org(input int s);
      int y = 0;
      for (int i = 0; i < NUM_STRIPS; i++) y = i < s ? y + int'(hgt(i)) : y;
      return y;
   endfunction

   localparam logic [4:0] HMAX = hmax();

   if (org(NUM_STRIPS) > ARRAY_H) begin : g_bad_heights
      $error("strip heights exceed ARRAY_H");
   end

   typedef enum logic [1:0] {IDLE, SCAN, COMMIT, RESP} state_t;

   state_t     state_q;
   logic [7:0] occ_q [NUM_STRIPS];
   logic [4:0] h_q;
   logic [7:0] w_q;
   logic       ill_q;
   logic [3:0] k_q;
   logic       best_vld_q, best_vld_d, best_ex_q, best_ex_d;
   logic [7:0] best_occ_q, best_occ_d;
   logic [3:0] best_idx_q, best_idx_d;
   logic       resp_valid_q;
   logic [1:0] strike_q;
   logic [7:0] x_q, y_q;
   logic [3:0] cnt_q;
   logic       fit, ex, illegal, placed;

   assign req_ready_o  = state_q == IDLE && !clear_i;
   assign resp_valid_o = resp_valid_q;
   assign strike_o     = strike_q;
   assign index_x_o    = x_q;
   assign index_y_o    = y_q;
   assign strike_cnt_o = cnt_q;
   assign illegal      = height_i == 5'd0 || width_i == 8'd0 || height_i > HMAX;
   assign placed       = !ill_q && best_vld_q;

   // only strips in the current window compete; index order keeps lowest-index ties
   always_comb begin
      best_vld_d = best_vld_q;
      best_ex_d  = best_ex_q;
      best_occ_d = best_occ_q;
      best_idx_d = best_idx_q;
      fit        = 1'b0;
      ex         = 1'b0;
      for (int s = 0; s < NUM_STRIPS; s++) begin
         ex  = hgt(s) == h_q || (hgt(s) == HMAX && h_q >= 5'(TALL_MIN));
         fit = (ex || (hgt(s) > h_q && hgt(s) - h_q <= 5'(SLACK))) &&
               {1'b0, occ_q[s]} + {1'b0, w_q} <= 9'(ARRAY_W);
         if (fit && k_q == 4'(s / STRIPS_PER_CYCLE) &&
             (!best_vld_d || occ_q[s] < best_occ_d || (occ_q[s] == best_occ_d && ex && !best_ex_d))) begin
            best_vld_d = 1'b1;
            best_ex_d  = ex;
            best_occ_d = occ_q[s];
            best_idx_d = 4'(s);
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         occ_q        <= '{default: '0};
         h_q          <= '0;
         w_q          <= '0;
         ill_q        <= 1'b0;
         k_q          <= '0;
         best_vld_q   <= 1'b0;
         best_ex_q    <= 1'b0;
         best_occ_q   <= '0;
         best_idx_q   <= '0;
         resp_valid_q <= 1'b0;
         strike_q     <= '0;
         x_q          <= '0;
         y_q          <= '0;
         cnt_q        <= '0;
      end else begin
         case (state_q)
            IDLE:
               if (clear_i) occ_q <= '{default: '0};
               else if (req_valid_i) begin
                  h_q        <= height_i;
                  w_q        <= width_i;
                  ill_q      <= illegal;
                  k_q        <= '0;
                  best_vld_q <= 1'b0;
                  state_q    <= illegal ? COMMIT : SCAN;
               end
            SCAN: begin
               best_vld_q <= best_vld_d;
               best_ex_q  <= best_ex_d;
               best_occ_q <= best_occ_d;
               best_idx_q <= best_idx_d;
               k_q        <= k_q + 4'd1;
               if (k_q == 4'(NSCAN - 1)) state_q <= COMMIT;
            end
            COMMIT: begin
               strike_q <= ill_q ? 2'd2 : best_vld_q ? 2'd0 : 2'd1;
               x_q      <= placed ? occ_q[best_idx_q] : 8'(ARRAY_W);
               y_q      <= placed ? 8'(org(int'(best_idx_q))) : 8'(ARRAY_W);
               if (placed) occ_q[best_idx_q] <= occ_q[best_idx_q] + w_q;
               else if (cnt_q != 4'd15) cnt_q <= cnt_q + 4'd1;
               resp_valid_q <= 1'b1;
               state_q      <= RESP;
            end
            RESP:
               if (resp_ready_i) begin
                  resp_valid_q <= 1'b0;
                  state_q      <= IDLE;
               end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_strip_alloc_engine.sv
// tb_strip_alloc_engine: directed vector table, corner sequences and a randomized
// run against a best-fit reference model of strip_alloc_engine.
module tb_strip_alloc_engine;
   localparam int AW = 128, HMAX = 16, SLACK = 1, TALL_MIN = 13, LAT = (13 + 3) / 4 + 1;
   localparam int HT [13] = '{12, 4, 11, 5, 10, 6, 9, 7, 8, 8, 16, 16, 16};

   logic       clk_i = 1'b0, rst_i = 1'b1, req_valid_i = 1'b0, clear_i = 1'b0, resp_ready_i = 1'b0;
   logic [4:0] height_i = '0;
   logic [7:0] width_i = '0;
   logic       req_ready_o, resp_valid_o;
   logic [1:0] strike_o;
   logic [7:0] index_x_o, index_y_o;
   logic [3:0] strike_cnt_o;

   int errors = 0, checks = 0;
   int m_occ [13];
   int m_cnt;

   typedef struct {int h, w, code, x, y, lat, cnt;} vec_t;
   vec_t tbl [13];

   strip_alloc_engine dut (
      .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .height_i(height_i), .width_i(width_i), .clear_i(clear_i), .resp_valid_o(resp_valid_o),
      .resp_ready_i(resp_ready_i), .strike_o(strike_o), .index_x_o(index_x_o),
      .index_y_o(index_y_o), .strike_cnt_o(strike_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string nm, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
      end
   endtask

   // best fit = smallest (occupancy, inexact) key; strict < keeps the lowest index
   function automatic void model(input int h, input int w, output int code, output int x, output int y);
      int best, bkey, key, d;
      bit tall;
      best = -1;
      bkey = 0;
      code = 2;
      x = AW;
      y = AW;
      if (h == 0 || w == 0 || h > HMAX) begin
         m_cnt = m_cnt < 15 ? m_cnt + 1 : 15;
         return;
      end
      for (int s = 0; s < 13; s++) begin
         d = HT[s] - h;
         tall = HT[s] == HMAX && h >= TALL_MIN;
         key = m_occ[s] * 2 + ((d == 0 || tall) ? 0 : 1);
         if (((d >= 0 && d <= SLACK) || tall) && m_occ[s] + w <= AW && (best < 0 || key < bkey)) begin
            best = s;
            bkey = key;
         end
      end
      if (best < 0) begin
         code = 1;
         m_cnt = m_cnt < 15 ? m_cnt + 1 : 15;
         return;
      end
      code = 0;
      x = m_occ[best];
      y = 0;
      for (int s = 0; s < best; s++) y += HT[s];
      m_occ[best] += w;
   endfunction

   task automatic send(input string nm, input int h, input int w, input int code, input int x,
                       input int y, input int lat, input int cnt, input int hold);
      int n = 0;
      @(negedge clk_i);
      chk({nm, " req_ready"}, int'(req_ready_o), 1);
      req_valid_i = 1'b1;
      height_i = 5'(h);
      width_i = 8'(w);
      @(posedge clk_i);
      #1 req_valid_i = 1'b0;
      do begin
         @(posedge clk_i);
         #1 n++;
      end while (!resp_valid_o && n < 20);
      chk({nm, " latency"}, n, lat);
      repeat (hold) begin
         @(negedge clk_i);
         chk({nm, " hold code"}, int'(strike_o), code);
         chk({nm, " hold x"}, int'(index_x_o), x);
         chk({nm, " hold y"}, int'(index_y_o), y);
         chk({nm, " hold ready"}, int'(req_ready_o), 0);
         chk({nm, " hold valid"}, int'(resp_valid_o), 1);
      end
      @(negedge clk_i);
      chk({nm, " code"}, int'(strike_o), code);
      chk({nm, " x"}, int'(index_x_o), x);
      chk({nm, " y"}, int'(index_y_o), y);
      chk({nm, " strike_cnt"}, int'(strike_cnt_o), cnt);
      resp_ready_i = 1'b1;
      @(posedge clk_i);
      #1 resp_ready_i = 1'b0;
      chk({nm, " valid drop"}, int'(resp_valid_o), 0);
   endtask

   initial begin
      int code, x, y;
      tbl = '{'{12, 20, 0, 0, 0, 5, 0},     '{12, 20, 0, 20, 0, 5, 0},   '{11, 10, 0, 0, 16, 5, 0},
              '{8, 100, 0, 0, 64, 5, 0},    '{8, 100, 0, 0, 72, 5, 0},   '{8, 100, 0, 0, 48, 5, 0},
              '{8, 100, 1, 128, 128, 5, 1}, '{0, 5, 2, 128, 128, 1, 2},  '{20, 5, 2, 128, 128, 1, 3},
              '{14, 128, 0, 0, 80, 5, 3},   '{14, 128, 0, 0, 96, 5, 3},  '{14, 128, 0, 0, 112, 5, 3},
              '{14, 128, 1, 128, 128, 5, 4}};
      repeat (3) @(posedge clk_i);
      @(negedge clk_i) rst_i = 1'b0;
      #1;
      chk("reset req_ready", int'(req_ready_o), 1);
      chk("reset resp_valid", int'(resp_valid_o), 0);
      chk("reset strike", int'(strike_o), 0);
      chk("reset x", int'(index_x_o), 0);
      chk("reset y", int'(index_y_o), 0);
      chk("reset cnt", int'(strike_cnt_o), 0);
      foreach (tbl[i])
         send($sformatf("vec%0d", i), tbl[i].h, tbl[i].w, tbl[i].code, tbl[i].x, tbl[i].y,
              tbl[i].lat, tbl[i].cnt, 0);
      for (int i = 0; i < 16; i++)
         send($sformatf("sat%0d", i), 0, 1, 2, AW, AW, 1, (5 + i) < 15 ? 5 + i : 15, 0);
      send("backpressure", 12, 20, 0, 40, 0, 5, 15, 10);
      @(negedge clk_i);
      clear_i = 1'b1;
      req_valid_i = 1'b1;
      height_i = 5'd12;
      width_i = 8'd20;
      #1 chk("clear blocks ready", int'(req_ready_o), 0);
      @(posedge clk_i);
      #1 clear_i = 1'b0;
      req_valid_i = 1'b0;
      send("after clear", 12, 20, 0, 0, 0, 5, 15, 0);
      @(negedge clk_i);
      req_valid_i = 1'b1;
      @(posedge clk_i);
      #1 req_valid_i = 1'b0;
      @(posedge clk_i);
      #1 rst_i = 1'b1;
      #1;
      chk("midscan rst req_ready", int'(req_ready_o), 1);
      chk("midscan rst resp_valid", int'(resp_valid_o), 0);
      chk("midscan rst strike", int'(strike_o), 0);
      chk("midscan rst x", int'(index_x_o), 0);
      chk("midscan rst y", int'(index_y_o), 0);
      chk("midscan rst cnt", int'(strike_cnt_o), 0);
      @(negedge clk_i) rst_i = 1'b0;
      send("post reset", 12, 20, 0, 0, 0, 5, 0, 0);
      @(negedge clk_i) clear_i = 1'b1;
      @(posedge clk_i);
      #1 clear_i = 1'b0;
      foreach (m_occ[s]) m_occ[s] = 0;
      m_cnt = 0;
      for (int i = 0; i < 150; i++) begin
         int h, w;
         if ($urandom_range(0, 15) == 0) begin
            @(negedge clk_i) clear_i = 1'b1;
            @(posedge clk_i);
            #1 clear_i = 1'b0;
            foreach (m_occ[s]) m_occ[s] = 0;
         end
         h = $urandom_range(0, 18);
         w = $urandom_range(0, 9) == 0 ? 0 : $urandom_range(1, 80);
         model(h, w, code, x, y);
         send($sformatf("rnd%0d h=%0d w=%0d", i, h, w), h, w, code, x, y, code == 2 ? 1 : LAT, m_cnt,
              $urandom_range(0, 2));
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
